// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin merge of two byte producers into a FIFO, drained
// into the serial transmitter under its write/busy handshake.
// Optional statistics (tx_count_o, drop_hint_o) are built when the macro
// UART_TX_SCHED_STATS_EN is defined; the default build omits them entirely.
module uart_tx_sched #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned HOLDOFF = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     req0_valid_i,
    input  logic [7:0]               req0_data_i,
    output logic                     req0_ready_o,
    input  logic                     req1_valid_i,
    input  logic [7:0]               req1_data_i,
    output logic                     req1_ready_o,
    output logic                     uart_wr_o,
    output logic [7:0]               uart_data_o,
    input  logic                     uart_busy_i,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     fifo_full_o,
    output logic                     fifo_empty_o,
    output logic                     sched_busy_o
`ifdef UART_TX_SCHED_STATS_EN
    ,
    output logic [15:0]              tx_count_o,
    output logic [1:0]               drop_hint_o
`endif
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
    localparam int unsigned HCNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic                rr_q;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]    level_q;
    logic [7:0]          mem [DEPTH];
    logic [7:0]          data_q;
    logic                wr_q;

    logic                full_c, empty_c;
    logic                grant0_c, grant1_c, push_c, pop_c, load_c;
    logic [7:0]          push_data_c;

    assign full_c  = (level_q == LVL_W'(DEPTH));
    assign empty_c = (level_q == '0);

    // Arbitration: full FIFO blocks both; a lone requester wins; a tie goes to rr
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (!full_c) begin
            if (req0_valid_i && !req1_valid_i) begin
                grant0_c = 1'b1;
            end else if (!req0_valid_i && req1_valid_i) begin
                grant1_c = 1'b1;
            end else if (req0_valid_i && req1_valid_i) begin
                grant0_c = !rr_q;
                grant1_c = rr_q;
            end
        end
    end

    assign push_c      = grant0_c | grant1_c;
    assign push_data_c = grant1_c ? req1_data_i : req0_data_i;

    // Round-robin pointer: after any grant the other requester is preferred
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_q <= 1'b0;
        end else if (push_c) begin
            rr_q <= grant0_c;
        end
    end

    // FIFO storage; contents need no reset because level gates every read
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem[wr_ptr_q] <= push_data_c;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two DEPTH
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Drain FSM state register (holdoff counter travels with the state)
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
        end
    end

    // Drain FSM next state; busy is ignored in HOLD to cover its rise latency
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            S_IDLE: begin
                if (!empty_c && !uart_busy_i) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_HOLD;
                hcnt_d  = HCNT_W'(HOLDOFF);
            end
            S_HOLD: begin
                if (hcnt_q <= HCNT_W'(1)) begin
                    state_d = S_WAIT;
                    hcnt_d  = '0;
                end else begin
                    hcnt_d = hcnt_q - HCNT_W'(1);
                end
            end
            S_WAIT: begin
                if (!uart_busy_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                hcnt_d  = '0;
            end
        endcase
    end

    // Drain FSM outputs: pop during ISSUE, preload the strobe/data on entry
    always_comb begin
        pop_c  = 1'b0;
        load_c = 1'b0;
        if (state_q == S_ISSUE && !empty_c) begin
            pop_c = 1'b1;
        end
        if (state_q == S_IDLE && state_d == S_ISSUE) begin
            load_c = 1'b1;
        end
    end

    // Registered transmitter strobe and data; data holds between issues
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_q   <= 1'b0;
            data_q <= 8'h00;
        end else begin
            wr_q <= load_c;
            if (load_c) begin
                data_q <= mem[rd_ptr_q];
            end
        end
    end

    assign req0_ready_o = grant0_c;
    assign req1_ready_o = grant1_c;
    assign uart_wr_o    = wr_q;
    assign uart_data_o  = data_q;
    assign fifo_level_o = level_q;
    assign fifo_full_o  = full_c;
    assign fifo_empty_o = empty_c;
    assign sched_busy_o = !empty_c || (state_q != S_IDLE);

`ifdef UART_TX_SCHED_STATS_EN
    logic [15:0] tx_count_q;
    logic [1:0]  drop_hint_q;

    // Issue counter (wraps) and sticky push-while-full hints
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tx_count_q  <= 16'h0000;
            drop_hint_q <= 2'b00;
        end else begin
            if (state_q == S_ISSUE) begin
                tx_count_q <= tx_count_q + 16'd1;
            end
            drop_hint_q <= drop_hint_q | ({req1_valid_i, req0_valid_i} & {2{full_c}});
        end
    end

    assign tx_count_o  = tx_count_q;
    assign drop_hint_o = drop_hint_q;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: arbitration table, scoreboarded
// byte order, latency/spacing, full boundary and asynchronous reset.
module tb_uart_tx_sched;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned HOLDOFF  = 2;
    localparam int          BUSY_LEN = 20;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       req0_valid_i = 1'b0;
    logic [7:0] req0_data_i = 8'h00;
    logic       req0_ready_o;
    logic       req1_valid_i = 1'b0;
    logic [7:0] req1_data_i = 8'h00;
    logic       req1_ready_o;
    logic       uart_wr_o;
    logic [7:0] uart_data_o;
    logic       uart_busy_i;
    logic [$clog2(DEPTH):0] fifo_level_o;
    logic       fifo_full_o;
    logic       fifo_empty_o;
    logic       sched_busy_o;
`ifdef UART_TX_SCHED_STATS_EN
    logic [15:0] tx_count_o;
    logic [1:0]  drop_hint_o;
`endif

    uart_tx_sched #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req0_valid_i (req0_valid_i),
        .req0_data_i  (req0_data_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_data_i  (req1_data_i),
        .req1_ready_o (req1_ready_o),
        .uart_wr_o    (uart_wr_o),
        .uart_data_o  (uart_data_o),
        .uart_busy_i  (uart_busy_i),
        .fifo_level_o (fifo_level_o),
        .fifo_full_o  (fifo_full_o),
        .fifo_empty_o (fifo_empty_o),
        .sched_busy_o (sched_busy_o)
`ifdef UART_TX_SCHED_STATS_EN
        ,
        .tx_count_o   (tx_count_o),
        .drop_hint_o  (drop_hint_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Transmitter busy model: rises the cycle after a strobe, lasts BUSY_LEN
    logic force_busy = 1'b0;
    logic bm_en = 1'b0;
    int   bm_cnt = 0;
    always @(posedge clk_i) begin
        if (!bm_en)          bm_cnt <= 0;
        else if (uart_wr_o)  bm_cnt <= BUSY_LEN;
        else if (bm_cnt > 0) bm_cnt <= bm_cnt - 1;
    end
    assign uart_busy_i = force_busy | (bm_cnt != 0);

    logic [7:0] sb[$];
    logic [7:0] src0[$];
    logic [7:0] src1[$];
    logic [7:0] sb_exp;
    int  n_wr = 0;
    int  last_wr_cyc = 0;
    int  last_push_cyc = 0;
    bit  spc_en = 1'b0;
    bit  have_prev = 1'b0;
    int  lvl_m = 0;
    bit  rr_m = 1'b0;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       r0;
        logic       r1;
        int         lvl;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the scoreboard head
    always @(negedge clk_i) begin
        if (uart_wr_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got data 0x%0h expected no strobe (cycle %0d)", uart_data_o, cyc);
            end else begin
                sb_exp = sb.pop_front();
                chk("tx_data", 32'(uart_data_o), 32'(sb_exp));
            end
            if (spc_en && have_prev) chk("issue_spacing", 32'(cyc - last_wr_cyc), 32'(HOLDOFF + 3));
            have_prev   = 1'b1;
            last_wr_cyc = cyc;
            n_wr++;
        end
    end

    task automatic do_reset();
        reset_i      = 1'b1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        bm_en        = 1'b0;
        force_busy   = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        sb.delete();
        lvl_m     = 0;
        rr_m      = 1'b0;
        have_prev = 1'b0;
        spc_en    = 1'b0;
        reset_i   = 1'b0;
    endtask

    // Drive src0/src1 with an independent arbitration/occupancy model
    task automatic run_phase(input int max_cycles, input int release_at);
        int i0 = 0;
        int i1 = 0;
        int k = 0;
        bit g0, g1, full_m, wr_now;
        while ((i0 < src0.size() || i1 < src1.size()) && k < max_cycles) begin
            if (k == release_at) force_busy = 1'b0;
            req0_valid_i = (i0 < src0.size());
            req0_data_i  = req0_valid_i ? src0[i0] : 8'h00;
            req1_valid_i = (i1 < src1.size());
            req1_data_i  = req1_valid_i ? src1[i1] : 8'h00;
            @(negedge clk_i);
            full_m = (lvl_m == int'(DEPTH));
            g0 = !full_m && req0_valid_i && (!req1_valid_i || !rr_m);
            g1 = !full_m && req1_valid_i && (!req0_valid_i || rr_m);
            chk("req0_ready", 32'(req0_ready_o), 32'(g0));
            chk("req1_ready", 32'(req1_ready_o), 32'(g1));
            chk("fifo_level", 32'(fifo_level_o), 32'(lvl_m));
            chk("fifo_full", 32'(fifo_full_o), 32'(full_m));
            chk("fifo_empty", 32'(fifo_empty_o), 32'(lvl_m == 0));
            if (g0) begin
                sb.push_back(src0[i0]);
                rr_m = 1'b1;
                last_push_cyc = cyc;
            end else if (g1) begin
                sb.push_back(src1[i1]);
                rr_m = 1'b0;
                last_push_cyc = cyc;
            end
            wr_now = uart_wr_o;
            @(posedge clk_i);
            #1;
            lvl_m = lvl_m + int'(g0 | g1) - int'(wr_now);
            if (g0) i0++;
            if (g1) i1++;
            k++;
        end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        if (i0 < src0.size() || i1 < src1.size()) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got %0d/%0d bytes accepted expected %0d/%0d", i0, i1, src0.size(), src1.size());
        end
    endtask

    task automatic wait_idle(input int bound, output int idle_cyc);
        bit done = 1'b0;
        idle_cyc = -1;
        for (int k = 0; k < bound && !done; k++) begin
            @(negedge clk_i);
            if (sb.size() == 0 && !sched_busy_o) begin
                done = 1'b1;
                idle_cyc = cyc;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d bytes pending expected 0", sb.size());
        end
        #1;
    endtask

    task automatic set_row(input int i, input logic v0, input logic v1,
                           input logic r0, input logic r1, input int lvl);
        tbl[i].v0  = v0;
        tbl[i].d0  = 8'hA0 + 8'(i);
        tbl[i].v1  = v1;
        tbl[i].d1  = 8'hB0 + 8'(i);
        tbl[i].r0  = r0;
        tbl[i].r1  = r1;
        tbl[i].lvl = lvl;
    endtask

    initial begin
        int idle_c;
        int n_before;
        bit seen;

        // Arbitration table, applied with the transmitter held busy
        set_row(0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        set_row(1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        set_row(2, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        set_row(3, 1'b1, 1'b1, 1'b1, 1'b0, 2);
        set_row(4, 1'b0, 1'b1, 1'b0, 1'b1, 3);
        set_row(5, 1'b0, 1'b1, 1'b0, 1'b1, 4);
        set_row(6, 1'b1, 1'b1, 1'b1, 1'b0, 5);
        set_row(7, 1'b1, 1'b0, 1'b1, 1'b0, 6);
        set_row(8, 1'b1, 1'b1, 1'b0, 1'b1, 7);
        set_row(9, 1'b0, 1'b0, 1'b0, 1'b0, 8);

        #3 reset_i = 1'b1;
        do_reset();

        // Reset then idle
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            chk("idle_wr", 32'(uart_wr_o), 32'd0);
            chk("idle_data", 32'(uart_data_o), 32'd0);
            chk("idle_empty", 32'(fifo_empty_o), 32'd1);
            chk("idle_level", 32'(fifo_level_o), 32'd0);
            chk("idle_sched_busy", 32'(sched_busy_o), 32'd0);
        end
        @(posedge clk_i);
        #1;

        // Single byte: latency and return to IDLE after busy falls
        do_reset();
        bm_en = 1'b1;
        n_before = n_wr;
        src0 = '{8'h41};
        src1.delete();
        run_phase(10, -1);
        wait_idle(200, idle_c);
        chk("single_count", 32'(n_wr - n_before), 32'd1);
        chk("single_latency", 32'(last_wr_cyc - last_push_cyc), 32'd2);
        chk("single_idle_return", 32'(idle_c - last_wr_cyc), 32'(BUSY_LEN + 2));

        // Contention: strict alternation 0x10,0x20,0x11,0x21,...
        do_reset();
        bm_en = 1'b1;
        n_before = n_wr;
        src0.delete();
        src1.delete();
        for (int i = 0; i < 6; i++) begin
            src0.push_back(8'h10 + 8'(i));
            src1.push_back(8'h20 + 8'(i));
        end
        run_phase(100, -1);
        wait_idle(2000, idle_c);
        chk("contention_count", 32'(n_wr - n_before), 32'd12);

        // Table-driven arbitration, then drain at minimum spacing
        do_reset();
        force_busy = 1'b1;
        n_before = n_wr;
        for (int i = 0; i < 10; i++) begin
            req0_valid_i = tbl[i].v0;
            req0_data_i  = tbl[i].d0;
            req1_valid_i = tbl[i].v1;
            req1_data_i  = tbl[i].d1;
            @(negedge clk_i);
            chk("tbl_ready0", 32'(req0_ready_o), 32'(tbl[i].r0));
            chk("tbl_ready1", 32'(req1_ready_o), 32'(tbl[i].r1));
            chk("tbl_level", 32'(fifo_level_o), 32'(tbl[i].lvl));
            chk("tbl_sched_busy", 32'(sched_busy_o), 32'(tbl[i].lvl != 0));
            if (tbl[i].r0) sb.push_back(tbl[i].d0);
            if (tbl[i].r1) sb.push_back(tbl[i].d1);
            @(posedge clk_i);
            #1;
        end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        spc_en = 1'b1;
        force_busy = 1'b0;
        wait_idle(500, idle_c);
        chk("tbl_drain_count", 32'(n_wr - n_before), 32'd8);

        // Full boundary: 17th byte refused until a pop has completed
        do_reset();
        force_busy = 1'b1;
        spc_en = 1'b1;
        n_before = n_wr;
        src0.delete();
        src1.delete();
        for (int i = 0; i < 17; i++) src0.push_back(8'h80 + 8'(i));
        run_phase(200, 25);
        wait_idle(500, idle_c);
        chk("full_drain_count", 32'(n_wr - n_before), 32'd17);
`ifdef UART_TX_SCHED_STATS_EN
        chk("stats_tx_count", 32'(tx_count_o), 32'd17);
        chk("stats_drop_hint", 32'(drop_hint_o), 32'd1);
`endif

        // Asynchronous reset during HOLD with 5 bytes queued
        do_reset();
        force_busy = 1'b1;
        src0.delete();
        src1.delete();
        for (int i = 0; i < 6; i++) src0.push_back(8'hC0 + 8'(i));
        run_phase(20, -1);
        bm_en = 1'b1;
        force_busy = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk_i);
            if (uart_wr_o) seen = 1'b1;
        end
        chk("rst_strobe_seen", 32'(seen), 32'd1);
        @(posedge clk_i);
        #1;
        chk("rst_pre_level", 32'(fifo_level_o), 32'd5);
        #2;
        reset_i = 1'b1;
        #1;
        chk("rst_wr", 32'(uart_wr_o), 32'd0);
        chk("rst_level", 32'(fifo_level_o), 32'd0);
        chk("rst_empty", 32'(fifo_empty_o), 32'd1);
        chk("rst_sched_busy", 32'(sched_busy_o), 32'd0);
        chk("rst_data", 32'(uart_data_o), 32'd0);
`ifdef UART_TX_SCHED_STATS_EN
        chk("rst_tx_count", 32'(tx_count_o), 32'd0);
        chk("rst_drop_hint", 32'(drop_hint_o), 32'd0);
`endif
        sb.delete();
        bm_en = 1'b0;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        n_before = n_wr;
        for (int k = 0; k < 40; k++) @(negedge clk_i);
        chk("rst_no_strobe", 32'(n_wr - n_before), 32'd0);
        chk("rst_post_level", 32'(fifo_level_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
